// File: rtl/rv32_alu.sv
// RV32I integer ALU: AND/XOR/OR/ADD/SUB/shifts/SLT/SLTU/PASS_B, optional MUL (RV32_ALU_MUL_EN).
// Latency: 1 cycle; result, zero flag and valid are registered together.
// Backpressure: none; a valid operand set is accepted on every cycle.
module rv32_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;
`ifdef RV32_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1011;
`endif

  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_valid;

  // Only the low five bits of B select the shift distance, so a shift by 32 wraps to 0.
  logic [4:0]       w_shamt;
  logic             w_lt_s;
  logic             w_lt_u;
  logic [WIDTH-1:0] w_result;

  assign w_shamt = in_b[4:0];
  assign w_lt_s  = $signed(in_a) < $signed(in_b);
  assign w_lt_u  = in_a < in_b;

  // Select the operation result; unused and reserved opcodes produce 0.
  always_comb begin
    w_result = '0;
    case (alu_opcode)
      OP_AND:  w_result = in_a & in_b;
      OP_XOR:  w_result = in_a ^ in_b;
      OP_OR:   w_result = in_a | in_b;
      OP_ADD:  w_result = in_a + in_b;
      OP_SUB:  w_result = in_a - in_b;
      OP_SLL:  w_result = in_a << w_shamt;
      OP_SRL:  w_result = in_a >> w_shamt;
      OP_SRA:  w_result = $unsigned($signed(in_a) >>> w_shamt);
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_lt_u};
      OP_PASS: w_result = in_b;
`ifdef RV32_ALU_MUL_EN
      // Low half of the product is identical for signed and unsigned operands.
      OP_MUL:  w_result = in_a * in_b;
`endif
      default: w_result = '0;
    endcase
  end

  // Capture result and zero flag on valid cycles; reset wins over a valid input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out  <= w_result;
        r_zero <= (w_result == '0);
      end
    end
  end

  assign alu_out   = r_out;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rv32_alu.sv
// Directed bench for rv32_alu: hand-computed vectors, reset, hold and back-to-back cases.
// Inputs are driven on the falling edge and outputs sampled 1 time unit after the rising edge.
// The DUT has no backpressure, so every drive is followed by exactly one clock of latency.
module tb_rv32_alu;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_valid;
  logic [31:0] alu_out;
  logic        zero;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  rv32_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_opcode (alu_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid   (in_valid),
    .alu_out    (alu_out),
    .zero       (zero),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation, wait for the capturing edge, then check all three outputs.
  task automatic op(input string tag, input logic [3:0] opc, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    rst = 1'b0; alu_opcode = opc; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".out"}, alu_out, exp);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, (exp == 32'h0)});
    chk({tag, ".vld"}, {31'b0, out_valid}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; alu_opcode = 4'b0011; in_a = 32'h1; in_b = 32'h2; in_valid = 1'b1;
    // Reset held for two edges, with a valid input present to show reset priority.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out",  alu_out, 32'h0);
    chk("rst.zero", {31'b0, zero}, 32'h1);
    chk("rst.vld",  {31'b0, out_valid}, 32'h0);

    // Idle after reset, opcode churn: outputs hold.
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; alu_opcode = 4'b0001; in_a = 32'hFFFF0000; in_b = 32'h0;
    @(posedge clk); #1;
    chk("idle.out",  alu_out, 32'h0);
    chk("idle.zero", {31'b0, zero}, 32'h1);
    chk("idle.vld",  {31'b0, out_valid}, 32'h0);

    op("and",  4'b0000, 32'hAAAA5555, 32'h5555AAAA, 32'h00000000);
    op("xor",  4'b0001, 32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFFF);

    // Opcode/operand change while invalid: previous XOR result must stay.
    @(negedge clk);
    in_valid = 1'b0; alu_opcode = 4'b0000; in_a = 32'h0; in_b = 32'h0;
    @(posedge clk); #1;
    chk("hold.out",  alu_out, 32'hFFFFFFFF);
    chk("hold.zero", {31'b0, zero}, 32'h0);
    chk("hold.vld",  {31'b0, out_valid}, 32'h0);

    op("add_wrap", 4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    op("add_ovf",  4'b0011, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
    op("sub",      4'b0100, 32'd5,        32'd7,        32'hFFFFFFFE);
    op("or",       4'b0010, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0);
    op("sll",      4'b0101, 32'h80000000, 32'd4,        32'h00000000);
    op("srl",      4'b0110, 32'h80000000, 32'd4,        32'h08000000);
    op("sra",      4'b0111, 32'h80000000, 32'd4,        32'hF8000000);
    op("sra_hi",   4'b0111, 32'h80000000, 32'h24,       32'hF8000000);
    op("sll_32",   4'b0101, 32'h12345678, 32'd32,       32'h12345678);
    op("sra_pos",  4'b0111, 32'h40000000, 32'd30,       32'h00000001);
    op("slt",      4'b1000, 32'h80000000, 32'h00000001, 32'h00000001);
    op("sltu",     4'b1001, 32'h80000000, 32'h00000001, 32'h00000000);
    op("slt_b",    4'b1000, 32'h80000000, 32'h7FFFFFFF, 32'h00000001);
    op("sltu_b",   4'b1001, 32'h80000000, 32'h7FFFFFFF, 32'h00000000);
    op("sltu_t",   4'b1001, 32'h00000001, 32'h80000000, 32'h00000001);
    op("pass_b",   4'b1010, 32'hDEADBEEF, 32'h12345000, 32'h12345000);
    op("rsv_f",    4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    op("pre_rsv",  4'b0011, 32'd1,        32'd1,        32'h00000002);
    op("rsv_c",    4'b1100, 32'h12345678, 32'h1,        32'h00000000);

`ifdef RV32_ALU_MUL_EN
    op("mul_big",  4'b1011, 32'h00010000, 32'h00010000, 32'h00000000);
    op("mul",      4'b1011, 32'd7,        32'd6,        32'h0000002A);
    op("mul_neg",  4'b1011, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD);
`else
    op("pre_1011", 4'b0011, 32'd1,        32'd1,        32'h00000002);
    op("rsv_1011", 4'b1011, 32'd7,        32'd6,        32'h00000000);
`endif

    // Back-to-back valid operations on consecutive edges.
    op("b2b_add", 4'b0011, 32'd1, 32'd2, 32'h00000003);
    op("b2b_xor", 4'b0001, 32'd3, 32'd3, 32'h00000000);
    op("b2b_sub", 4'b0100, 32'd2, 32'd3, 32'hFFFFFFFF);

    // Reset asserted mid-stream with a valid input still present.
    @(negedge clk);
    rst = 1'b1; alu_opcode = 4'b0011; in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("mrst.out",  alu_out, 32'h0);
    chk("mrst.zero", {31'b0, zero}, 32'h1);
    chk("mrst.vld",  {31'b0, out_valid}, 32'h0);

    op("post_rst", 4'b0011, 32'd10, 32'd20, 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
32-bit integer ALU for the single-cycle RV32I datapath. It computes one of the RV32I register/immediate operations on two 32-bit operands. The result and a zero flag are registered, giving one cycle of latency. Its output feeds the writeback mux, and its zero flag feeds the branch-decision logic.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- alu_opcode  input  4  operation select
- in_a  input  32  operand A (rs1 or PC)
- in_b  input  32  operand B (rs2 or immediate)
- in_valid  input  1  operands and opcode are valid this cycle
- alu_out  output  32  registered result
- zero  output  1  registered flag: alu_out == 0
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - On a clk rising edge with rst=1, alu_out=0, zero=1, out_valid=0.
  - rst has priority over in_valid.
- Latency and capture:
  - When in_valid=1 on an edge, the result of that cycle's inputs appears on alu_out on that same edge (1-cycle latency).
  - zero updates together with alu_out, and out_valid=1.
  - When in_valid=0, alu_out and zero hold their values and out_valid=0.
  - Back-to-back valid inputs are accepted every cycle; there is no stall or backpressure.
- Opcode map (all arithmetic is mod 2^32):
  - 0000 AND: a & b
  - 0001 XOR: a ^ b
  - 0010 OR: a | b
  - 0011 ADD: a + b, carry discarded
  - 0100 SUB: a - b, borrow discarded
  - 0101 SLL: a << b[4:0]
  - 0110 SRL: logical a >> b[4:0]
  - 0111 SRA: arithmetic a >>> b[4:0], sign-filled from a[31]
  - 1000 SLT: 1 if signed(a) < signed(b), else 0; zero-extended to 32 bits
  - 1001 SLTU: 1 if unsigned(a) < unsigned(b), else 0
  - 1010 PASS_B: b (used for LUI)
  - 1011: see Optional Feature
  - 1100-1111 reserved: result 0, so zero=1
- Boundary conditions:
  - Shift amounts use only b[4:0]; b[31:5] is ignored (shift by 32 equals shift by 0).
  - No overflow flag is produced; signed overflow wraps silently.
  - SLT with a=0x80000000, b=0x7FFFFFFF gives 1; SLTU with the same operands gives 0.
  - An opcode change while in_valid=0 has no effect on the outputs.

Optional Feature:
- Macro: RV32_ALU_MUL_EN
- Defined: opcode 1011 is MUL, the low 32 bits of a*b. The result is the same for signed and unsigned operands. Latency remains 1 cycle.
- Undefined: opcode 1011 is treated as reserved (result 0) and no multiplier is synthesized.

Test Plan:
- rst=1 for 2 cycles -> alu_out=0x00000000, zero=1, out_valid=0. Then rst=0 with in_valid=0 -> outputs hold.
- Opcode 0000, a=0xAAAA5555, b=0x5555AAAA, in_valid=1 -> next edge alu_out=0x00000000, zero=1, out_valid=1. Opcode 0001 with the same operands -> 0xFFFFFFFF, zero=0.
- ADD 0xFFFFFFFF+1 -> 0x00000000, zero=1. SUB 5-7 -> 0xFFFFFFFE. OR 0xF0F00000|0x0000F0F0 -> 0xF0F0F0F0.
- With a=0x80000000:
  - SLL b=4 -> 0x00000000
  - SRL b=4 -> 0x08000000
  - SRA b=4 -> 0xF8000000
  - SRA b=0x24 -> 0xF8000000 (only b[4:0]=4 is used)
- With a=0x80000000, b=1: SLT -> 1, SLTU -> 0. PASS_B with b=0x12345000 -> 0x12345000. Opcode 1111 -> 0.
- Back-to-back ADD(1,2), XOR(3,3), SUB(2,3) on consecutive cycles -> 3, 0, 0xFFFFFFFF. Asserting rst during the stream clears outputs on the next edge. With RV32_ALU_MUL_EN, 1011 on 0x10000*0x10000 -> 0x00000000 and on 7*6 -> 0x0000002A.
